// File: rtl/bz_sound_pkg.sv
// Shared types and constants for the sound control / noise scheduling block.
//   gain_state_t : mute-ramp FSM states
//   BIT_*        : bit positions inside the CPU sound-latch byte
//   sample_t     : signed 16-bit audio sample
//   sat16()      : clamps a wide signed value to the sample_t range
package bz_sound_pkg;

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    ON,
    RAMP_DOWN
  } gain_state_t;

  localparam int unsigned BIT_EXPLO_LS = 0;
  localparam int unsigned BIT_SHELL_LS = 1;
  localparam int unsigned BIT_EXPLO_EN = 2;
  localparam int unsigned BIT_SHELL_EN = 3;
  localparam int unsigned BIT_SOUND_EN = 5;

  localparam logic [7:0] GAIN_MAX = 8'd255;

  typedef logic        [7:0]  cpu_byte_t;
  typedef logic signed [15:0] sample_t;
  typedef logic signed [16:0] sum_t;
  typedef logic signed [25:0] prod_t;

  function automatic sample_t sat16(input prod_t v);
    if (v > 26'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -26'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/sound_ctrl_sched_if.sv
// CPU write port into the sound latch.
//   cpu_wr  : one-clk write strobe
//   cpu_din : write data byte
// master drives the bus (CPU side), slave receives it (sound block).
interface sound_ctrl_sched_if;
  import bz_sound_pkg::*;

  logic      cpu_wr;
  cpu_byte_t cpu_din;

  modport master (output cpu_wr, output cpu_din);
  modport slave  (input  cpu_wr, input  cpu_din);

endinterface

// File: rtl/sound_clk_enables.sv
// Clock-enable generator for the sound block.
//   clk, reset_n  : system clock, asynchronous active-low reset
//   clk_3MHz_en   : one-clk pulse every DIV_3M system clocks
//   clk_12KHz_en  : one-clk pulse every DIV_12K clk_3MHz_en pulses,
//                   always coincident with a clk_3MHz_en pulse
module sound_clk_enables #(
  parameter int unsigned DIV_3M  = 4,
  parameter int unsigned DIV_12K = 256
) (
  input  logic clk,
  input  logic reset_n,
  output logic clk_3MHz_en,
  output logic clk_12KHz_en
);

  localparam int unsigned W3  = $clog2(DIV_3M);
  localparam int unsigned W12 = $clog2(DIV_12K);

  logic [W3-1:0]  div3;
  logic [W12-1:0] div12;
  logic           wrap3;
  logic           wrap12;

  assign wrap3  = (div3  == W3'(DIV_3M - 1));
  assign wrap12 = (div12 == W12'(DIV_12K - 1));

  // Both enables are registered off the same wrap condition, so the slow
  // pulse lines up exactly with a fast pulse and neither is wider than 1 clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div3         <= '0;
      div12        <= '0;
      clk_3MHz_en  <= 1'b0;
      clk_12KHz_en <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      clk_3MHz_en  <= wrap3;
      clk_12KHz_en <= wrap3 && wrap12;
      if (wrap3) begin
        div3  <= '0;
        div12 <= wrap12 ? '0 : div12 + W12'(1);
      end else begin
        div3  <= div3 + W3'(1);
      end
    end
  end

endmodule

// File: rtl/sound_ctrl_sched.sv
// Sound control register and shell/explosion noise scheduler.
//   clk, reset_n        : system clock, asynchronous active-low reset
//   cpu                 : sound-latch write port (cpu_wr / cpu_din)
//   noise_explo/shell   : signed noise samples from the two generators
//   clk_3MHz_en         : fast clock enable (also paces the mixer)
//   clk_12KHz_en        : slow clock enable (paces the mute ramp)
//   sound_enable        : latched global enable, drives the noise shifters
//   explo_en/ls,
//   shell_en/ls         : latched level enables and loud/soft selects
//   mix_out, mix_valid  : gain-scaled, saturated mix and its update strobe
module sound_ctrl_sched
  import bz_sound_pkg::*;
#(
  parameter int unsigned DIV_3M  = 4,
  parameter int unsigned DIV_12K = 256,
  parameter int unsigned RAMP_SH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sound_ctrl_sched_if.slave        cpu,
  input  sample_t                  noise_explo,
  input  sample_t                  noise_shell,
  output logic                     clk_3MHz_en,
  output logic                     clk_12KHz_en,
  output logic                     sound_enable,
  output logic                     explo_en,
  output logic                     explo_ls,
  output logic                     shell_en,
  output logic                     shell_ls,
  output sample_t                  mix_out,
  output logic                     mix_valid
);

  localparam logic [7:0] RAMP_STEP = 8'(2 ** RAMP_SH);

  sound_clk_enables #(
    .DIV_3M  (DIV_3M),
    .DIV_12K (DIV_12K)
  ) u_clk_enables (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_3MHz_en  (clk_3MHz_en),
    .clk_12KHz_en (clk_12KHz_en)
  );

  // ---------------------------------------------------------------------
  // Sound latch: the last write wins, outputs follow one clock later.
  // ---------------------------------------------------------------------
  logic unused_din;
  assign unused_din = ^{cpu.cpu_din[7:6], cpu.cpu_din[4]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sound_enable <= 1'b0;
      explo_en     <= 1'b0;
      explo_ls     <= 1'b0;
      shell_en     <= 1'b0;
      shell_ls     <= 1'b0;
    end else if (cpu.cpu_wr) begin
      sound_enable <= cpu.cpu_din[BIT_SOUND_EN];
      explo_en     <= cpu.cpu_din[BIT_EXPLO_EN];
      explo_ls     <= cpu.cpu_din[BIT_EXPLO_LS];
      shell_en     <= cpu.cpu_din[BIT_SHELL_EN];
      shell_ls     <= cpu.cpu_din[BIT_SHELL_LS];
    end
  end

  // ---------------------------------------------------------------------
  // Mute-ramp FSM. The direction is decided purely from the current state
  // and sound_enable, and always steps from the present gain, so reversing
  // mid-ramp never jumps.
  // ---------------------------------------------------------------------
  gain_state_t state_q, state_d;
  logic [7:0]  gain_q,  gain_d;
  logic        step_up, step_dn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MUTED;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d = state_q;
    gain_d  = gain_q;
    step_up = 1'b0;
    step_dn = 1'b0;

    if (clk_12KHz_en) begin
      case (state_q)
        MUTED:     step_up = sound_enable;
        ON:        step_dn = !sound_enable;
        RAMP_UP,
        RAMP_DOWN: begin
          step_up = sound_enable;
          step_dn = !sound_enable;
        end
        default:   step_dn = 1'b1;
      endcase
    end

    if (step_up) begin
      if (gain_q >= GAIN_MAX - RAMP_STEP) begin
        gain_d  = GAIN_MAX;
        state_d = ON;
      end else begin
        gain_d  = gain_q + RAMP_STEP;
        state_d = RAMP_UP;
      end
    end else if (step_dn) begin
      if (gain_q <= RAMP_STEP) begin
        gain_d  = '0;
        state_d = MUTED;
      end else begin
        gain_d  = gain_q - RAMP_STEP;
        state_d = RAMP_DOWN;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Mixer: stage 1 adds the two samples at 17 bits, stage 2 scales by the
  // gain (Q0.8), shifts back and clamps. s1_valid keeps mix_valid low until
  // stage 1 holds a real sum after reset.
  // ---------------------------------------------------------------------
  sum_t  sum_q;
  logic  s1_valid;
  prod_t sum_x;
  prod_t gain_x;
  prod_t prod;
  prod_t scaled;

  assign sum_x  = 26'(sum_q);
  assign gain_x = {18'd0, gain_q};
  assign prod   = sum_x * gain_x;
  assign scaled = prod >>> 8;

  // NOTE: the pipeline registers are few and feed straight to outputs, so
  // they are all reset; nothing here is large enough to be a memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q     <= '0;
      s1_valid  <= 1'b0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= clk_3MHz_en && s1_valid;
      if (clk_3MHz_en) begin
        sum_q    <= 17'(noise_explo) + 17'(noise_shell);
        s1_valid <= 1'b1;
        if (s1_valid) begin
          mix_out <= sat16(scaled);
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_ctrl_sched.sv
module tb_sound_ctrl_sched;
  import bz_sound_pkg::*;

  logic    clk = 1'b0;
  logic    reset_n = 1'b0;
  sample_t noise_explo, noise_shell, mix_out;
  logic    clk_3MHz_en, clk_12KHz_en, sound_enable;
  logic    explo_en, explo_ls, shell_en, shell_ls, mix_valid;

  sound_ctrl_sched_if bus ();

  sound_ctrl_sched #(
    .DIV_3M  (4),
    .DIV_12K (256),
    .RAMP_SH (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu          (bus.slave),
    .noise_explo  (noise_explo),
    .noise_shell  (noise_shell),
    .clk_3MHz_en  (clk_3MHz_en),
    .clk_12KHz_en (clk_12KHz_en),
    .sound_enable (sound_enable),
    .explo_en     (explo_en),
    .explo_ls     (explo_ls),
    .shell_en     (shell_en),
    .shell_ls     (shell_ls),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {sound_enable, shell_en, explo_en, shell_ls, explo_ls}
  typedef struct {
    logic [7:0] din;
    logic [4:0] expect_bits;
  } latch_vec_t;

  typedef struct {
    sample_t explo;
    sample_t shell;
    sample_t expect_mix;
  } mix_vec_t;

  latch_vec_t lv[7];
  mix_vec_t   mv[7];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] latch_bits();
    return {sound_enable, shell_en, explo_en, shell_ls, explo_ls};
  endfunction

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_din  = '0;
    noise_explo  = '0;
    noise_shell  = '0;
    clocks(3);
    reset_n = 1'b1;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    bus.cpu_wr  = 1'b1;
    bus.cpu_din = d;
    @(negedge clk);
    bus.cpu_wr  = 1'b0;
  endtask

  task automatic wait_12k(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (clk_12KHz_en !== 1'b1 && n < 3000);
    check(name, clk_12KHz_en, 1);
  endtask

  // With explo=256, shell=0 the mixer output equals the gain directly.
  task automatic gain_after_12k(input string name, input int exp_gain);
    wait_12k(name);
    clocks(16);
    check(name, mix_out, exp_gain);
  endtask

  initial begin
    int bad3, bad12, n3, n12, first3, first12, first_valid, n3_at_valid;

    lv[0] = '{8'h2F, 5'b11111};
    lv[1] = '{8'h04, 5'b00100};
    lv[2] = '{8'hD5, 5'b00101};
    lv[3] = '{8'h3F, 5'b11111};
    lv[4] = '{8'h20, 5'b10000};
    lv[5] = '{8'h1A, 5'b01010};
    lv[6] = '{8'h00, 5'b00000};

    mv[0] = '{16'sd30000,  16'sd30000,  16'sd32767};
    mv[1] = '{-16'sd30000, -16'sd30000, -16'sd32768};
    mv[2] = '{16'sd1000,   16'sd2000,   16'sd2988};
    mv[3] = '{-16'sd1000,  -16'sd500,   -16'sd1495};
    mv[4] = '{16'sd32767,  -16'sd32768, -16'sd1};
    mv[5] = '{16'sd0,      16'sd0,      16'sd0};
    mv[6] = '{16'sd256,    16'sd0,      16'sd255};

    // ---- reset state ----
    reset_n     = 1'b0;
    bus.cpu_wr  = 1'b0;
    bus.cpu_din = '0;
    noise_explo = '0;
    noise_shell = '0;
    clocks(3);
    check("reset_enables", {clk_3MHz_en, clk_12KHz_en}, 0);
    check("reset_latch", latch_bits(), 0);
    check("reset_mix_out", mix_out, 0);
    check("reset_mix_valid", mix_valid, 0);

    // ---- clock enables over 4096 clocks ----
    reset_n = 1'b1;
    bad3 = 0; bad12 = 0; n3 = 0; n12 = 0; first3 = 0; first12 = 0;
    for (int k = 1; k <= 4096; k++) begin
      @(negedge clk);
      if (clk_3MHz_en !== ((k % 4) == 0)) bad3++;
      if (clk_12KHz_en !== ((k % 1024) == 0)) bad12++;
      if (clk_3MHz_en === 1'b1) begin
        n3++;
        if (first3 == 0) first3 = k;
      end
      if (clk_12KHz_en === 1'b1) begin
        n12++;
        if (first12 == 0) first12 = k;
      end
    end
    check("en3_pattern_errors", bad3, 0);
    check("en12_pattern_errors", bad12, 0);
    check("en3_pulse_count", n3, 1024);
    check("en12_pulse_count", n12, 4);
    check("en3_first_clk", first3, 4);
    check("en12_first_clk", first12, 1024);

    // ---- latch vectors ----
    for (int i = 0; i < 7; i++) begin
      cpu_write(lv[i].din);
      check("latch_vector", latch_bits(), lv[i].expect_bits);
    end

    // back-to-back writes, then hold with no write
    bus.cpu_wr  = 1'b1;
    bus.cpu_din = 8'h2F;
    @(negedge clk);
    check("b2b_first", latch_bits(), 5'b11111);
    bus.cpu_din = 8'h04;
    @(negedge clk);
    bus.cpu_wr  = 1'b0;
    check("b2b_second", latch_bits(), 5'b00100);
    bus.cpu_din = 8'hFF;
    clocks(3);
    check("latch_hold", latch_bits(), 5'b00100);

    // ---- ramp up / mix saturation / ramp down ----
    apply_reset();
    noise_explo = 16'sd256;
    noise_shell = 16'sd0;
    cpu_write(8'h20);
    for (int i = 1; i <= 16; i++) begin
      gain_after_12k("ramp_up", (i < 16) ? 16 * i : 255);
    end
    gain_after_12k("on_hold", 255);

    for (int i = 0; i < 7; i++) begin
      noise_explo = mv[i].explo;
      noise_shell = mv[i].shell;
      clocks(16);
      check("mix_vector", mix_out, mv[i].expect_mix);
    end
    noise_explo = 16'sd256;
    noise_shell = 16'sd0;

    cpu_write(8'h00);
    for (int i = 1; i <= 16; i++) begin
      gain_after_12k("ramp_down", (255 - 16 * i > 0) ? 255 - 16 * i : 0);
    end
    gain_after_12k("muted_hold", 0);

    // ---- reversal mid-ramp ----
    cpu_write(8'h20);
    for (int i = 1; i <= 6; i++) begin
      gain_after_12k("ramp_to_96", 16 * i);
    end
    cpu_write(8'h00);
    gain_after_12k("reverse_down", 80);
    gain_after_12k("reverse_down2", 64);
    cpu_write(8'h20);
    gain_after_12k("reverse_up", 80);

    // ---- asynchronous reset mid-ramp ----
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_flags",
          {clk_3MHz_en, clk_12KHz_en, sound_enable, explo_en, explo_ls,
           shell_en, shell_ls, mix_valid}, 0);
    check("async_reset_mix", mix_out, 0);
    clocks(2);
    reset_n = 1'b1;
    n3 = 0; first_valid = 0; n3_at_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mix_valid === 1'b1 && first_valid == 0) begin
        first_valid = k;
        n3_at_valid = n3;
      end
      if (clk_3MHz_en === 1'b1) n3++;
    end
    check("valid_after_reset_clk", first_valid, 9);
    check("en3_before_valid", n3_at_valid, 2);
    check("mix_after_reset", mix_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
